// File: rtl/bp_be_thread_wait_ctrl_pkg.sv
// Shared types for the multithreaded BE thread block/wake controller.
package bp_be_thread_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    e_wait_run,
    e_wait_wait,
    e_wait_wake
  } bp_be_wait_state_e;

  typedef enum logic [1:0] {
    e_wake_none,
    e_wake_addr,
    e_wake_timeout,
    e_wake_explicit
  } bp_be_wake_cause_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_be_thread_wait_ctrl_slot.sv
// One hardware thread's RUN/WAIT/WAKE state, monitored line, timeout counter and wake cause.
// Optional feature macro: BP_BE_THREAD_WAIT_PENDING_WAKE_EN (latches explicit wakes seen in RUN).
module bp_be_thread_wait_ctrl_slot
  import bp_be_thread_wait_ctrl_pkg::*;
#(
  parameter int line_width_p = 34,
  parameter int cnt_width_p  = 16,
  parameter bit timeout_en_p = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    arm_i,
  input  logic [line_width_p-1:0] arm_line_i,
  input  logic [cnt_width_p-1:0]  arm_timeout_i,
  input  logic                    snoop_v_i,
  input  logic [line_width_p-1:0] snoop_line_i,
  input  logic                    wake_i,
  output logic                    run_o,
  output logic                    blocked_o,
  output logic                    wake_pulse_o,
  output logic [1:0]              wake_cause_o
);

  localparam logic [1:0] StRun  = e_wait_run;
  localparam logic [1:0] StWait = e_wait_wait;
  localparam logic [1:0] StWake = e_wait_wake;

  logic [1:0]              state_q, state_d;
  logic [line_width_p-1:0] line_q, line_d;
  logic [cnt_width_p-1:0]  cnt_q, cnt_d;
  logic [1:0]              cause_q, cause_d;
  logic                    pending;
  logic                    arm_snoop_hit, wait_snoop_hit, timeout_hit;

`ifdef BP_BE_THREAD_WAIT_PENDING_WAKE_EN
  logic pending_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_q <= 1'b0;
    end else if (state_q == StRun) begin
      if (arm_i) begin
        pending_q <= 1'b0;
      end else if (wake_i) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign pending = pending_q;
`else
  assign pending = 1'b0;
`endif

  assign arm_snoop_hit  = snoop_v_i && (snoop_line_i == arm_line_i);
  assign wait_snoop_hit = snoop_v_i && (snoop_line_i == line_q);
  // A loaded count of 0 means infinite, so only the 1 -> 0 step expires.
  assign timeout_hit    = timeout_en_p && (cnt_q == cnt_width_p'(1));

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      StRun: begin
        if (arm_i) begin
          line_d = arm_line_i;
          cnt_d  = timeout_en_p ? arm_timeout_i : '0;
          // Wake already raised in the arm cycle must not be lost.
          if (wake_i || pending) begin
            state_d = StWake;
            cause_d = e_wake_explicit;
          end else if (arm_snoop_hit) begin
            state_d = StWake;
            cause_d = e_wake_addr;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_width_p'(1);
        end
        if (wake_i) begin
          state_d = StWake;
          cause_d = e_wake_explicit;
        end else if (wait_snoop_hit) begin
          state_d = StWake;
          cause_d = e_wake_addr;
        end else if (timeout_hit) begin
          state_d = StWake;
          cause_d = e_wake_timeout;
        end
      end
      StWake:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StRun;
      line_q  <= '0;
      cnt_q   <= '0;
      cause_q <= e_wake_none;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign run_o        = (state_q == StRun);
  assign blocked_o    = (state_q == StWait);
  assign wake_pulse_o = (state_q == StWake);
  assign wake_cause_o = cause_q;

endmodule

// File: rtl/bp_be_thread_wait_ctrl.sv
// Per-thread mwait block/wake controller feeding the MT scheduler's thread-blocked vector.
// Optional feature macro: BP_BE_THREAD_WAIT_PENDING_WAKE_EN (remember explicit wakes to RUN threads).
module bp_be_thread_wait_ctrl
  import bp_be_thread_wait_ctrl_pkg::*;
#(
  parameter int num_threads_p   = 4,
  parameter int paddr_width_p   = 40,
  parameter int line_offset_p   = 6,
  parameter int timeout_width_p = 16,
  localparam int tid_w          = safe_clog2(num_threads_p),
  localparam int timeout_w      = (timeout_width_p == 0) ? 1 : timeout_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       wait_v_i,
  output logic                       wait_ready_o,
  input  logic [tid_w-1:0]           wait_tid_i,
  input  logic [paddr_width_p-1:0]   wait_addr_i,
  input  logic [timeout_w-1:0]       wait_timeout_i,
  input  logic                       snoop_v_i,
  input  logic [paddr_width_p-1:0]   snoop_addr_i,
  input  logic                       wake_v_i,
  input  logic [tid_w-1:0]           wake_tid_i,
  output logic [num_threads_p-1:0]   thread_blocked_o,
  output logic [num_threads_p-1:0]   wake_pulse_o,
  output logic [2*num_threads_p-1:0] wake_cause_o
);

  localparam int line_w = paddr_width_p - line_offset_p;

  logic [num_threads_p-1:0] run;
  logic [line_w-1:0]        wait_line, snoop_line;
  logic                     wait_hs;

  assign wait_line  = wait_addr_i[paddr_width_p-1:line_offset_p];
  assign snoop_line = snoop_addr_i[paddr_width_p-1:line_offset_p];
  assign wait_hs    = wait_v_i && wait_ready_o;

  // Out-of-range tids match no slot, so ready stays low for them.
  always_comb begin
    wait_ready_o = 1'b0;
    for (int t = 0; t < num_threads_p; t++) begin
      if (wait_tid_i == tid_w'(t)) begin
        wait_ready_o = run[t];
      end
    end
  end

  for (genvar t = 0; t < num_threads_p; t++) begin : g_slot
    bp_be_thread_wait_ctrl_slot #(
      .line_width_p (line_w),
      .cnt_width_p  (timeout_w),
      .timeout_en_p (timeout_width_p != 0)
    ) u_slot (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .arm_i         (wait_hs && (wait_tid_i == tid_w'(t))),
      .arm_line_i    (wait_line),
      .arm_timeout_i (wait_timeout_i),
      .snoop_v_i     (snoop_v_i),
      .snoop_line_i  (snoop_line),
      .wake_i        (wake_v_i && (wake_tid_i == tid_w'(t))),
      .run_o         (run[t]),
      .blocked_o     (thread_blocked_o[t]),
      .wake_pulse_o  (wake_pulse_o[t]),
      .wake_cause_o  (wake_cause_o[2*t+:2])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && wait_v_i) begin
      assert (int'(wait_tid_i) < num_threads_p);
    end
    if (reset_n_i && wake_v_i) begin
      assert (int'(wake_tid_i) < num_threads_p);
    end
  end

endmodule

// File: tb/tb_bp_be_thread_wait_ctrl.sv
// Directed bench for bp_be_thread_wait_ctrl: reset, addr/timeout/explicit wakes, collisions, arm races.
module tb_bp_be_thread_wait_ctrl;

  logic        clk;
  logic        reset_n;
  logic        wait_v;
  logic        wait_ready;
  logic [1:0]  wait_tid;
  logic [39:0] wait_addr;
  logic [15:0] wait_to;
  logic        snoop_v;
  logic [39:0] snoop_addr;
  logic        wake_v;
  logic [1:0]  wake_tid;
  logic [3:0]  blocked;
  logic [3:0]  pulse;
  logic [7:0]  cause;

  int passed = 0;
  int total  = 0;

  bp_be_thread_wait_ctrl #(
    .num_threads_p   (4),
    .paddr_width_p   (40),
    .line_offset_p   (6),
    .timeout_width_p (16)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .wait_v_i         (wait_v),
    .wait_ready_o     (wait_ready),
    .wait_tid_i       (wait_tid),
    .wait_addr_i      (wait_addr),
    .wait_timeout_i   (wait_to),
    .snoop_v_i        (snoop_v),
    .snoop_addr_i     (snoop_addr),
    .wake_v_i         (wake_v),
    .wake_tid_i       (wake_tid),
    .thread_blocked_o (blocked),
    .wake_pulse_o     (pulse),
    .wake_cause_o     (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [1:0] tid, input logic [39:0] addr, input logic [15:0] to);
    wait_v    = 1'b1;
    wait_tid  = tid;
    wait_addr = addr;
    wait_to   = to;
  endtask

  initial begin
    reset_n    = 1'b0;
    wait_v     = 1'b1;
    wait_tid   = 2'd0;
    wait_addr  = '0;
    wait_to    = '0;
    snoop_v    = 1'b0;
    snoop_addr = '0;
    wake_v     = 1'b0;
    wake_tid   = 2'd0;

    // Reset held with an arm request pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blocked", 64'(blocked), 64'h0);
    chk("rst_pulse", 64'(pulse), 64'h0);
    chk("rst_cause", 64'(cause), 64'h0);
    reset_n   = 1'b1;
    wait_addr = 40'h1000;
    #1;
    chk("rst_ready", 64'(wait_ready), 64'h1);
    tick();
    chk("arm_after_rst", 64'(blocked), 64'h1);
    wait_v   = 1'b0;
    wake_v   = 1'b1;
    wake_tid = 2'd0;
    tick();
    chk("expl_pulse", 64'(pulse), 64'h1);
    chk("expl_blocked", 64'(blocked), 64'h0);
    chk("expl_cause", 64'(cause), 64'h03);
    wake_v = 1'b0;
    tick();
    chk("expl_pulse_end", 64'(pulse), 64'h0);

    // Address wake on tid2; neighbouring line does not match
    arm(2'd2, 40'h80_0000_0040, 16'd0);
    tick();
    chk("addr_blocked", 64'(blocked), 64'h4);
    wait_v     = 1'b0;
    snoop_v    = 1'b1;
    snoop_addr = 40'h80_0000_0080;
    tick();
    chk("addr_miss_blocked", 64'(blocked), 64'h4);
    chk("addr_miss_pulse", 64'(pulse), 64'h0);
    snoop_v = 1'b0;
    repeat (2) tick();
    snoop_v    = 1'b1;
    snoop_addr = 40'h80_0000_007C;
    tick();
    chk("addr_hit_blocked", 64'(blocked), 64'h0);
    chk("addr_hit_pulse", 64'(pulse), 64'h4);
    chk("addr_hit_cause", 64'(cause), 64'h13);
    snoop_v = 1'b0;
    tick();
    chk("addr_pulse_end", 64'(pulse), 64'h0);

    // Timeout of 3: blocked for exactly three sampled cycles
    arm(2'd1, 40'h9000, 16'd3);
    tick();
    chk("to_blocked_1", 64'(blocked), 64'h2);
    wait_v = 1'b0;
    tick();
    chk("to_blocked_2", 64'(blocked), 64'h2);
    tick();
    chk("to_blocked_3", 64'(blocked), 64'h2);
    tick();
    chk("to_wake_blocked", 64'(blocked), 64'h0);
    chk("to_wake_pulse", 64'(pulse), 64'h2);
    chk("to_wake_cause", 64'(cause), 64'h1B);
    tick();
    chk("to_pulse_end", 64'(pulse), 64'h0);

    // Collision: tid3 timeout, shared-line snoop and explicit wake of tid0 in one cycle
    arm(2'd3, 40'hA000, 16'd2);
    tick();
    arm(2'd0, 40'hA010, 16'd0);
    tick();
    chk("coll_blocked", 64'(blocked), 64'h9);
    wait_v     = 1'b0;
    snoop_v    = 1'b1;
    snoop_addr = 40'hA038;
    wake_v     = 1'b1;
    wake_tid   = 2'd0;
    tick();
    chk("coll_pulse", 64'(pulse), 64'h9);
    chk("coll_blocked_clr", 64'(blocked), 64'h0);
    chk("coll_cause", 64'(cause), 64'h5B);
    snoop_v = 1'b0;
    wake_v  = 1'b0;
    tick();
    chk("coll_pulse_end", 64'(pulse), 64'h0);

    // Arm race: matching snoop in the arm cycle, then re-arm stalled during WAKE
    arm(2'd1, 40'hB000, 16'd0);
    snoop_v    = 1'b1;
    snoop_addr = 40'hB010;
    #1;
    chk("race_ready", 64'(wait_ready), 64'h1);
    tick();
    chk("race_blocked", 64'(blocked), 64'h0);
    chk("race_pulse", 64'(pulse), 64'h2);
    chk("race_cause", 64'(cause), 64'h57);
    snoop_v   = 1'b0;
    wait_addr = 40'hC000;
    #1;
    chk("race_wake_ready", 64'(wait_ready), 64'h0);
    tick();
    chk("race_run_blocked", 64'(blocked), 64'h0);
    chk("race_run_pulse", 64'(pulse), 64'h0);
    chk("race_run_ready", 64'(wait_ready), 64'h1);
    tick();
    chk("race_rearm", 64'(blocked), 64'h2);
    wait_v   = 1'b0;
    wake_v   = 1'b1;
    wake_tid = 2'd1;
    tick();
    chk("race_expl_pulse", 64'(pulse), 64'h2);
    chk("race_expl_cause", 64'(cause), 64'h5F);
    wake_v = 1'b0;
    tick();

    // Explicit wake to a RUN thread, then arm it
    wake_v   = 1'b1;
    wake_tid = 2'd2;
    tick();
    chk("run_wake_pulse", 64'(pulse), 64'h0);
    chk("run_wake_blocked", 64'(blocked), 64'h0);
    wake_v = 1'b0;
    arm(2'd2, 40'hD000, 16'd0);
    tick();
    wait_v = 1'b0;
`ifdef BP_BE_THREAD_WAIT_PENDING_WAKE_EN
    chk("pend_pulse", 64'(pulse), 64'h4);
    chk("pend_blocked", 64'(blocked), 64'h0);
    chk("pend_cause", 64'(cause), 64'h7F);
`else
    chk("nopend_blocked", 64'(blocked), 64'h4);
    chk("nopend_pulse", 64'(pulse), 64'h0);
    wake_v   = 1'b1;
    wake_tid = 2'd2;
    tick();
    wake_v = 1'b0;
    chk("nopend_cause", 64'(cause), 64'h7F);
`endif
    tick();

    // Asynchronous reset in the middle of a wait
    arm(2'd0, 40'hE000, 16'd0);
    tick();
    chk("mid_blocked", 64'(blocked), 64'h1);
    wait_v = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_blocked", 64'(blocked), 64'h0);
    chk("mid_rst_cause", 64'(cause), 64'h0);
    chk("mid_rst_pulse", 64'(pulse), 64'h0);
    #1;
    reset_n = 1'b1;
    tick();
    chk("mid_post_blocked", 64'(blocked), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
